// File: rtl/pc_unit_8b.sv
// -----------------------------------------------------------------------------
// pc_unit_8b
//
// 8-bit program counter with an optional return-address stack.
// Each enabled cycle the next fetch address is chosen with this priority:
//   ret > call > jump > sequential increment
// The chosen address is held in a register that drives the instruction-memory
// address. The jump/call target comes from the upstream 8-bit operand mux and
// is only ever captured into a register, so there is no combinational path
// from jump_addr to pc.
//
// Configuration macro: PC_STACK_EN
//   defined   : LIFO return stack of STACK_DEPTH entries; call pushes pc+1,
//               ret pops it. Overflow and underflow set a sticky stack_err.
//   undefined : no stack storage; call acts as jump, ret acts as increment,
//               and the stack status outputs are constant
//               (count 0, empty 1, full 0, err 0).
//
// Parameters
//   RESET_VECTOR  PC value forced by reset
//   STACK_DEPTH   return-stack entries, legal range 1..7
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   advance enable; low holds all state and ignores commands
//   jump         in   load jump_addr into pc
//   call         in   push return address, load jump_addr into pc
//   ret          in   pop return address into pc
//   jump_addr    in   [7:0] target address
//   pc           out  [7:0] current fetch address (registered)
//   stack_count  out  [2:0] occupied stack entries
//   stack_full   out  stack_count == STACK_DEPTH
//   stack_empty  out  stack_count == 0
//   stack_err    out  sticky overflow/underflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module pc_unit_8b #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         STACK_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       jump,
  input  logic       call,
  input  logic       ret,
  input  logic [7:0] jump_addr,
  output logic [7:0] pc,
  output logic [2:0] stack_count,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  // Stack depth in the same width as the stack pointer.
  localparam logic [2:0] DEPTH = 3'(STACK_DEPTH);

  logic [7:0] pc_r;
  logic [7:0] pc_inc_s;
  logic [7:0] pc_next_s;

  // Sequential successor; 8-bit arithmetic wraps FF -> 00 naturally.
  assign pc_inc_s = pc_r + 8'd1;

`ifdef PC_STACK_EN

  logic [7:0] stack_mem_r [STACK_DEPTH];
  logic [2:0] sp_r;       // number of occupied entries; next free slot index
  logic       err_r;
  logic [7:0] top_s;
  logic       push_s;
  logic       pop_s;
  logic       err_set_s;
  logic       full_s;
  logic       empty_s;

  assign full_s  = (sp_r == DEPTH);
  assign empty_s = (sp_r == 3'd0);

  // Top-of-stack read: the entry just below the pointer.
  always_comb begin
    top_s = 8'h00;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      top_s = (sp_r == 3'(i + 1)) ? stack_mem_r[i] : top_s;
    end
  end

  // Command decode: next pc plus stack push/pop/error strobes.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    pc_next_s = pc_r;
    if (!en) begin
      pc_next_s = pc_r;
    end else if (ret) begin
      if (!empty_s) begin
        pop_s     = 1'b1;
        pc_next_s = top_s;
      end else begin
        // Underflow: fall through to sequential fetch and flag it.
        err_set_s = 1'b1;
        pc_next_s = pc_inc_s;
      end
    end else if (call) begin
      pc_next_s = jump_addr;
      if (!full_s) begin
        push_s = 1'b1;
      end else begin
        // Overflow: the jump still happens, the return address is lost.
        err_set_s = 1'b1;
      end
    end else if (jump) begin
      pc_next_s = jump_addr;
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // Stack pointer, sticky error flag and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r  <= 3'd0;
      err_r <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem_r[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        sp_r <= sp_r + 3'd1;
      end else if (pop_s) begin
        sp_r <= sp_r - 3'd1;
      end else begin
        sp_r <= sp_r;
      end

      if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end

      // Only the slot at the pointer is written; the return address is pc+1.
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_s && (sp_r == 3'(i))) begin
          stack_mem_r[i] <= pc_inc_s;
        end else begin
          stack_mem_r[i] <= stack_mem_r[i];
        end
      end
    end
  end

  assign stack_count = sp_r;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign stack_err   = err_r;

`else

  // Command decode without a stack: ret is a plain increment, call is a jump.
  always_comb begin
    pc_next_s = pc_r;
    if (!en) begin
      pc_next_s = pc_r;
    end else if (ret) begin
      pc_next_s = pc_inc_s;
    end else if (call || jump) begin
      pc_next_s = jump_addr;
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  assign stack_count = 3'd0;
  // Legal depths are 1..7, so this is constant low.
  assign stack_full  = (DEPTH == 3'd0);
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;

`endif

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_VECTOR;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: tb/tb_pc_unit_8b.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pc_unit_8b. Directed vectors with hand-computed
// expectations. Stack scenarios are selected by PC_STACK_EN to match the
// build of the design under test.
// -----------------------------------------------------------------------------
module tb_pc_unit_8b;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       jump;
  logic       call;
  logic       ret;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic [2:0] stack_count;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int checks;
  int errors;

  pc_unit_8b #(
    .RESET_VECTOR (8'h00),
    .STACK_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .stack_count (stack_count),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic e, input logic j, input logic c, input logic r, input logic [7:0] a);
    en = e; jump = j; call = c; ret = r; jump_addr = a;
  endtask

  task automatic test_reset();
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    step();
    step();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 8'h00); end
    checks++; if (stack_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stack_count); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", stack_empty); end
    checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", stack_full); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", stack_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_increment();
    logic [7:0] exp_pc [3];
    exp_pc[0] = 8'h01; exp_pc[1] = 8'h02; exp_pc[2] = 8'h03;
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL incr_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
    end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL incr_empty got %b want 1", stack_empty); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL incr_err got %b want 0", stack_err); end
  endtask

  task automatic test_wrap_hold();
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'hFE);
    step();
    checks++; if (pc !== 8'hFE) begin errors++; $display("FAIL wrap_jump got %h want fe", pc); end
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_ff got %h want ff", pc); end
    step();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_00 got %h want 00", pc); end
    cmd(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    step();
    step();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL hold_pc got %h want 00", pc); end
    checks++; if (stack_count !== 3'd0) begin errors++; $display("FAIL hold_count got %0d want 0", stack_count); end
  endtask

`ifdef PC_STACK_EN
  task automatic test_nested_call();
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
    step();
    checks++; if (pc !== 8'h10) begin errors++; $display("FAIL nest_start got %h want 10", pc); end
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
    step();
    checks++; if (pc !== 8'h40 || stack_count !== 3'd1) begin errors++; $display("FAIL nest_call1 got pc %h cnt %0d want 40 1", pc, stack_count); end
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h80);
    step();
    checks++; if (pc !== 8'h80 || stack_count !== 3'd2) begin errors++; $display("FAIL nest_call2 got pc %h cnt %0d want 80 2", pc, stack_count); end
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    checks++; if (pc !== 8'h41 || stack_count !== 3'd1) begin errors++; $display("FAIL nest_ret1 got pc %h cnt %0d want 41 1", pc, stack_count); end
    step();
    checks++; if (pc !== 8'h11 || stack_empty !== 1'b1) begin errors++; $display("FAIL nest_ret2 got pc %h empty %b want 11 1", pc, stack_empty); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL nest_err got %b want 0", stack_err); end
  endtask

  task automatic test_overflow_underflow();
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'hA0);
    step();
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'hA0);
    for (int i = 0; i < 4; i++) step();
    checks++; if (stack_full !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got full %b err %b want 1 0", stack_full, stack_err); end
    step();
    checks++; if (stack_count !== 3'd4 || stack_full !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d full %b want 4 1", stack_count, stack_full); end
    checks++; if (stack_err !== 1'b1 || pc !== 8'hA0) begin errors++; $display("FAIL ovf_err got err %b pc %h want 1 a0", stack_err, pc); end
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pc !== 8'hA1 || stack_count !== 3'(3 - i)) begin errors++; $display("FAIL unf_ret[%0d] got pc %h cnt %0d want a1 %0d", i, pc, stack_count, 3 - i); end
    end
    step();
    checks++; if (pc !== 8'hA2 || stack_err !== 1'b1 || stack_empty !== 1'b1) begin errors++; $display("FAIL unf_5th got pc %h err %b empty %b want a2 1 1", pc, stack_err, stack_empty); end
  endtask

  task automatic test_priority();
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h50);
    step();
    checks++; if (pc !== 8'h50 || stack_count !== 3'd1) begin errors++; $display("FAIL prio_call got pc %h cnt %0d want 50 1", pc, stack_count); end
    cmd(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
    step();
    checks++; if (pc !== 8'hA3 || stack_count !== 3'd0) begin errors++; $display("FAIL prio_ret got pc %h cnt %0d want a3 0", pc, stack_count); end
    cmd(1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
    step();
    checks++; if (pc !== 8'h66 || stack_count !== 3'd1) begin errors++; $display("FAIL prio_call_jump got pc %h cnt %0d want 66 1", pc, stack_count); end
  endtask
`else
  task automatic test_macro_off();
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h30);
    step();
    checks++; if (pc !== 8'h30) begin errors++; $display("FAIL off_call got %h want 30", pc); end
    checks++; if (stack_count !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("FAIL off_call_stat got cnt %0d empty %b full %b want 0 1 0", stack_count, stack_empty, stack_full); end
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    checks++; if (pc !== 8'h31) begin errors++; $display("FAIL off_ret got %h want 31", pc); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL off_err got %b want 0", stack_err); end
    cmd(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
    step();
    checks++; if (pc !== 8'h32) begin errors++; $display("FAIL off_prio got %h want 32", pc); end
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    step();
    checks++; if (pc !== 8'h5A) begin errors++; $display("FAIL off_jump got %h want 5a", pc); end
  endtask
`endif

  task automatic test_async_reset();
`ifdef PC_STACK_EN
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
`else
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
`endif
    step();
    checks++; if (pc !== 8'h77) begin errors++; $display("FAIL areset_pre got %h want 77", pc); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 8'h00 || stack_count !== 3'd0) begin errors++; $display("FAIL areset_pc got pc %h cnt %0d want 00 0", pc, stack_count); end
    checks++; if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL areset_flags got empty %b err %b want 1 0", stack_empty, stack_err); end
    rst_n = 1'b1;
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h24);
    step();
    checks++; if (pc !== 8'h24) begin errors++; $display("FAIL areset_first_cmd got %h want 24", pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    test_reset();
    test_increment();
    test_wrap_hold();
`ifdef PC_STACK_EN
    test_nested_call();
    test_overflow_underflow();
    test_priority();
`else
    test_macro_off();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
